// File: rtl/frame_config_sequencer_pkg.sv
// Shared definitions for the eFPGA configuration sequencer.
// Holds the state encoding, the default sync word and the width of the frame counter.
package efpga_cfg_pkg;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] ADDR   = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] CHECK  = 3'd3;
    localparam logic [2:0] STROBE = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE   = IDLE,
        ST_ADDR   = ADDR,
        ST_DATA   = DATA,
        ST_CHECK  = CHECK,
        ST_STROBE = STROBE
    } cfg_state_e;

    localparam logic [31:0] SYNC_WORD    = 32'hFAB0_FAB1;
    localparam int          FRAMES_CNT_W = 16;

endpackage

// File: rtl/frame_config_sequencer_if.sv
// Valid/ready configuration word stream feeding frame_config_sequencer.
// The master drives words, the slave (the sequencer) answers with s_ready.
interface frame_config_sequencer_if #(
    parameter int W = 32
);
    logic [W-1:0] s_data;
    logic         s_valid;
    logic         s_ready;

    modport master (output s_data, output s_valid, input s_ready);
    modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/frame_config_sequencer.sv
// frame_config_sequencer: turns a configuration word stream into fabric frame writes.
// A session opens with the sync word; each frame is one address word, NumberOfRows+2
// data words and a one-cycle LongFrameStrobe. An address word with the desync bit set
// closes the session.
// Optional feature macro: FRAME_CHECKSUM_EN (XOR trailer word checked before each strobe).
module frame_config_sequencer
    import efpga_cfg_pkg::*;
#(
    parameter int          NumberOfRows     = 10,
    parameter int          FrameBitsPerRow  = 32,
    parameter int          MaxFramesPerCol  = 20,
    parameter int          FrameSelectWidth = 5,
    parameter int          desync_flag      = 20,
    parameter logic [31:0] SyncWord         = SYNC_WORD
) (
    input  logic                                        CLK,
    input  logic                                        resetn,
    frame_config_sequencer_if.slave                     cfg,
    output logic [FrameBitsPerRow-1:0]                  FrameAddressRegister,
    output logic [FrameBitsPerRow*(NumberOfRows+2)-1:0] FrameData,
    output logic                                        LongFrameStrobe,
    output logic                                        ComActive,
    output logic [FRAMES_CNT_W-1:0]                     FramesWritten,
    output logic                                        ChkErr
);

    localparam int WORDS = NumberOfRows + 2;
    localparam int ROW_W = $clog2(WORDS);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(WORDS - 1);

    // The desync bit and the frame-strobe field must both sit below the column-select field.
    if ((desync_flag >= FrameBitsPerRow - FrameSelectWidth) ||
        (MaxFramesPerCol > FrameBitsPerRow - FrameSelectWidth)) begin : g_bad_params
        $error("frame_config_sequencer: address field layout does not fit the word");
    end

    cfg_state_e                        state_r;
    cfg_state_e                        state_next_s;
    logic                              ready_r;
    logic                              strobe_r;
    logic                              active_r;
    logic [ROW_W-1:0]                  row_r;
    logic [FrameBitsPerRow-1:0]        addr_r;
    logic [FrameBitsPerRow*WORDS-1:0]  data_r;
    logic [FRAMES_CNT_W-1:0]           frames_r;
    logic                              accept_s;
    logic                              addr_acc_s;
    logic                              data_acc_s;
    logic [WORDS-1:0]                  slice_en_s;
    logic                              chk_fail_s;

    assign accept_s   = cfg.s_valid && ready_r;
    assign addr_acc_s = accept_s && (state_r == ST_ADDR);
    assign data_acc_s = accept_s && (state_r == ST_DATA);

`ifdef FRAME_CHECKSUM_EN
    logic [FrameBitsPerRow-1:0] acc_r;
    logic                       chk_err_r;

    function automatic logic [FrameBitsPerRow-1:0] chk_fold(
        input logic [FrameBitsPerRow-1:0] acc,
        input logic [FrameBitsPerRow-1:0] word
    );
        return acc ^ word;
    endfunction
`endif

    // Next-state decode; also flags a trailer mismatch in the checksum build.
    always_comb begin
        state_next_s = state_r;
        chk_fail_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && (cfg.s_data == SyncWord)) state_next_s = ST_ADDR;
                else                                      state_next_s = ST_IDLE;
            end
            ST_ADDR: begin
                if (accept_s) begin
                    if (cfg.s_data[desync_flag]) state_next_s = ST_IDLE;
                    else                         state_next_s = ST_DATA;
                end else begin
                    state_next_s = ST_ADDR;
                end
            end
            ST_DATA: begin
`ifdef FRAME_CHECKSUM_EN
                if (accept_s && (row_r == LAST_ROW)) state_next_s = ST_CHECK;
                else                                 state_next_s = ST_DATA;
`else
                if (accept_s && (row_r == LAST_ROW)) state_next_s = ST_STROBE;
                else                                 state_next_s = ST_DATA;
`endif
            end
`ifdef FRAME_CHECKSUM_EN
            ST_CHECK: begin
                if (accept_s) begin
                    if (cfg.s_data == acc_r) begin
                        state_next_s = ST_STROBE;
                    end else begin
                        state_next_s = ST_IDLE;
                        chk_fail_s   = 1'b1;
                    end
                end else begin
                    state_next_s = ST_CHECK;
                end
            end
`endif
            ST_STROBE: state_next_s = ST_ADDR;
            default:   state_next_s = ST_IDLE;
        endcase
    end

    // Decoded write enable for the data slice addressed by the row counter.
    always_comb begin
        slice_en_s = '0;
        for (int k = 0; k < WORDS; k++) begin
            if (data_acc_s && (row_r == ROW_W'(k))) slice_en_s[k] = 1'b1;
            else                                    slice_en_s[k] = 1'b0;
        end
    end

    // State register plus the registered handshake/status outputs derived from the next state.
    always_ff @(posedge CLK) begin
        if (!resetn) begin
            state_r  <= ST_IDLE;
            ready_r  <= 1'b0;
            strobe_r <= 1'b0;
            active_r <= 1'b0;
        end else begin
            state_r  <= state_next_s;
            ready_r  <= (state_next_s != ST_STROBE);
            strobe_r <= (state_next_s == ST_STROBE);
            active_r <= (state_next_s != ST_IDLE);
        end
    end

    // Frame datapath: address latch, row counter, wide data register and frame counter.
    always_ff @(posedge CLK) begin
        if (!resetn) begin
            addr_r   <= '0;
            row_r    <= '0;
            data_r   <= '0;
            frames_r <= '0;
        end else begin
            if (addr_acc_s) begin
                addr_r <= cfg.s_data;
                row_r  <= '0;
            end else if (data_acc_s && (row_r != LAST_ROW)) begin
                row_r <= row_r + ROW_W'(1);
            end
            for (int k = 0; k < WORDS; k++) begin
                if (slice_en_s[k]) data_r[k*FrameBitsPerRow +: FrameBitsPerRow] <= cfg.s_data;
            end
            if ((state_r == ST_STROBE) && (frames_r != {FRAMES_CNT_W{1'b1}})) begin
                frames_r <= frames_r + FRAMES_CNT_W'(1);
            end
        end
    end

`ifdef FRAME_CHECKSUM_EN
    // XOR accumulator over address and data words, and the sticky checksum error flag.
    always_ff @(posedge CLK) begin
        if (!resetn) begin
            acc_r     <= '0;
            chk_err_r <= 1'b0;
        end else begin
            if (addr_acc_s)      acc_r <= cfg.s_data;
            else if (data_acc_s) acc_r <= chk_fold(acc_r, cfg.s_data);
            if (chk_fail_s)      chk_err_r <= 1'b1;
        end
    end

    assign ChkErr = chk_err_r;
`else
    assign ChkErr = 1'b0;
`endif

    assign cfg.s_ready           = ready_r;
    assign FrameAddressRegister  = addr_r;
    assign FrameData             = data_r;
    assign LongFrameStrobe       = strobe_r;
    assign ComActive             = active_r;
    assign FramesWritten         = frames_r;

endmodule

// File: tb/tb_frame_config_sequencer.sv
// Self-checking bench for frame_config_sequencer (NumberOfRows=10, 12 data words per frame).
// Every cycle is compared against a word-stream reference model; directed sequences and a
// vector table add explicit expectations. Works with or without FRAME_CHECKSUM_EN.
module tb_frame_config_sequencer;
    import efpga_cfg_pkg::*;

    localparam int W  = 32;
    localparam int NW = 12;

    logic CLK    = 1'b0;
    logic resetn = 1'b0;
    always #5 CLK = ~CLK;

    frame_config_sequencer_if #(.W(W)) cfg_if ();

    logic [W-1:0]    FrameAddressRegister;
    logic [W*NW-1:0] FrameData;
    logic            LongFrameStrobe;
    logic            ComActive;
    logic [15:0]     FramesWritten;
    logic            ChkErr;

    frame_config_sequencer #(.NumberOfRows(10), .FrameBitsPerRow(W)) dut (
        .CLK                  (CLK),
        .resetn               (resetn),
        .cfg                  (cfg_if.slave),
        .FrameAddressRegister (FrameAddressRegister),
        .FrameData            (FrameData),
        .LongFrameStrobe      (LongFrameStrobe),
        .ComActive            (ComActive),
        .FramesWritten        (FramesWritten),
        .ChkErr               (ChkErr)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_wide(input string name, input logic [W*NW-1:0] act, input logic [W*NW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: interprets accepted words as a session of frames.
    int           m_phase;    // 0 waiting for sync, 1 want address, 2 collecting data, 3 want checksum
    bit           m_strobe;
    bit           m_ready;
    bit           m_chkerr;
    logic [W-1:0] m_addr;
    logic [W-1:0] m_data [NW];
    int           m_count;
    int           m_frames;

    function automatic logic [W*NW-1:0] m_pack();
        logic [W*NW-1:0] p;
        for (int k = 0; k < NW; k++) p[k*W +: W] = m_data[k];
        return p;
    endfunction

    function automatic logic [W-1:0] m_xor();
        logic [W-1:0] r;
        r = m_addr;
        for (int k = 0; k < NW; k++) r ^= m_data[k];
        return r;
    endfunction

    task automatic model_clock(input logic rst_n_v, input logic v, input logic [W-1:0] d);
        bit acc;
        if (!rst_n_v) begin
            m_phase = 0; m_strobe = 0; m_ready = 0; m_chkerr = 0;
            m_addr = '0; m_count = 0; m_frames = 0;
            for (int k = 0; k < NW; k++) m_data[k] = '0;
        end else begin
            acc = v && m_ready;
            if (m_strobe) begin
                m_strobe = 0;
                if (m_frames < 65535) m_frames++;
                m_phase = 1;
            end else if (acc) begin
                case (m_phase)
                    0: if (d == SYNC_WORD) m_phase = 1;
                    1: begin
                        m_addr = d;
                        if (d[20]) m_phase = 0;
                        else begin m_phase = 2; m_count = 0; end
                    end
                    2: begin
                        m_data[m_count] = d;
                        m_count++;
                        if (m_count == NW) begin
`ifdef FRAME_CHECKSUM_EN
                            m_phase = 3;
`else
                            m_strobe = 1;
`endif
                        end
                    end
                    3: begin
                        if (d == m_xor()) begin m_strobe = 1; m_phase = 2; end
                        else begin m_chkerr = 1; m_phase = 0; end
                    end
                    default: m_phase = 0;
                endcase
            end
            m_ready = !m_strobe;
        end
    endtask

    task automatic compare_all();
        chk("strobe", LongFrameStrobe, m_strobe);
        chk("ready", cfg_if.s_ready, m_ready);
        chk("active", ComActive, m_phase != 0);
        chk("addr", FrameAddressRegister, m_addr);
        chk("frames", FramesWritten, m_frames);
        chk("chkerr", ChkErr, m_chkerr);
        chk_wide("frame_data", FrameData, m_pack());
    endtask

    // One clock: drive inputs, let the edge happen, advance the model, compare.
    task automatic step(input logic rst_n_v, input logic v, input logic [W-1:0] d);
        resetn         = rst_n_v;
        cfg_if.s_valid = v;
        cfg_if.s_data  = d;
        @(posedge CLK);
        model_clock(rst_n_v, v, d);
        #1;
        compare_all();
    endtask

    task automatic send_trailer(input logic [W-1:0] addr, input logic [W-1:0] base, input logic flip);
`ifdef FRAME_CHECKSUM_EN
        logic [W-1:0] t;
        t = addr;
        for (int k = 0; k < NW; k++) t ^= base + W'(k);
        step(1'b1, 1'b1, t ^ {31'd0, flip});
`endif
    endtask

    typedef struct {
        logic         v;
        logic [W-1:0] d;
        logic         e_strobe;
        logic         e_active;
        logic [W-1:0] e_addr;
    } vec_t;

    vec_t            vecs [9];
    logic [W*NW-1:0] exp_fd;
    int              strobes;
    logic [W-1:0]    rd;
    int              sel;

    initial begin
        vecs[0] = '{1'b1, 32'h0010_0000, 1'b0, 1'b0, 32'h0010_0000};
        vecs[1] = '{1'b1, 32'h0000_1234, 1'b0, 1'b0, 32'h0010_0000};
        vecs[2] = '{1'b1, 32'h0000_DEAD, 1'b0, 1'b0, 32'h0010_0000};
        vecs[3] = '{1'b1, SYNC_WORD,     1'b0, 1'b1, 32'h0010_0000};
        vecs[4] = '{1'b1, 32'h0010_0000, 1'b0, 1'b0, 32'h0010_0000};
        vecs[5] = '{1'b1, 32'h0000_0077, 1'b0, 1'b0, 32'h0010_0000};
        vecs[6] = '{1'b0, SYNC_WORD,     1'b0, 1'b0, 32'h0010_0000};
        vecs[7] = '{1'b1, SYNC_WORD,     1'b0, 1'b1, 32'h0010_0000};
        vecs[8] = '{1'b1, 32'h0010_0000, 1'b0, 1'b0, 32'h0010_0000};
        for (int k = 0; k < NW; k++) exp_fd[k*W +: W] = W'(k);

        cfg_if.s_valid = 1'b0;
        cfg_if.s_data  = '0;

        // Test 1: reset state, then one complete frame.
        step(1'b0, 1'b0, '0);
        step(1'b0, 1'b1, SYNC_WORD);
        chk("rst_ready", cfg_if.s_ready, 1'b0);
        chk("rst_active", ComActive, 1'b0);
        chk("rst_frames", FramesWritten, 16'd0);
        chk("rst_strobe", LongFrameStrobe, 1'b0);
        chk_wide("rst_data", FrameData, '0);
        step(1'b1, 1'b0, '0);
        chk("ready_after_rst", cfg_if.s_ready, 1'b1);
        step(1'b1, 1'b1, SYNC_WORD);
        chk("t1_active", ComActive, 1'b1);
        step(1'b1, 1'b1, 32'hF800_0001);
        for (int k = 0; k < NW; k++) begin
            step(1'b1, 1'b1, W'(k));
            if (k < NW - 1) chk("t1_no_early_strobe", LongFrameStrobe, 1'b0);
        end
        send_trailer(32'hF800_0001, 32'h0, 1'b0);
        chk("t1_strobe", LongFrameStrobe, 1'b1);
        chk("t1_ready_in_strobe", cfg_if.s_ready, 1'b0);
        step(1'b1, 1'b0, '0);
        chk("t1_strobe_end", LongFrameStrobe, 1'b0);
        chk("t1_frames", FramesWritten, 16'd1);
        chk("t1_addr", FrameAddressRegister, 32'hF800_0001);
        chk_wide("t1_data", FrameData, exp_fd);

        // Tests 2 and 3: dropped words in IDLE, desync address, stall in IDLE.
        for (int i = 0; i < 9; i++) begin
            step(1'b1, vecs[i].v, vecs[i].d);
            chk("tbl_strobe", LongFrameStrobe, vecs[i].e_strobe);
            chk("tbl_active", ComActive, vecs[i].e_active);
            chk("tbl_addr", FrameAddressRegister, vecs[i].e_addr);
        end
        chk("t3_frames", FramesWritten, 16'd1);

        // Test 4: s_valid toggling every cycle through a full frame.
        strobes = 0;
        step(1'b1, 1'b1, SYNC_WORD);
        step(1'b1, 1'b0, $urandom);
        step(1'b1, 1'b1, 32'hF800_0001);
        step(1'b1, 1'b0, $urandom);
        for (int k = 0; k < NW; k++) begin
            step(1'b1, 1'b1, W'(k));
            if (k < NW - 1) begin
                if (LongFrameStrobe) strobes++;
                step(1'b1, 1'b0, $urandom);
                if (LongFrameStrobe) strobes++;
            end
        end
`ifdef FRAME_CHECKSUM_EN
        if (LongFrameStrobe) strobes++;
        step(1'b1, 1'b0, $urandom);
        if (LongFrameStrobe) strobes++;
`endif
        send_trailer(32'hF800_0001, 32'h0, 1'b0);
        chk("t4_early_strobes", strobes, 0);
        chk("t4_strobe", LongFrameStrobe, 1'b1);
        chk("t4_ready_in_strobe", cfg_if.s_ready, 1'b0);
        step(1'b1, 1'b0, '0);
        chk_wide("t4_data", FrameData, exp_fd);
        chk("t4_frames", FramesWritten, 16'd2);

        // Test 5: reset in the middle of a frame, then a fresh frame.
        step(1'b1, 1'b1, 32'h0000_0042);
        for (int k = 0; k < 6; k++) step(1'b1, 1'b1, 32'h100 + W'(k));
        step(1'b0, 1'b1, 32'h106);
        chk("t5_rst_frames", FramesWritten, 16'd0);
        chk("t5_rst_strobe", LongFrameStrobe, 1'b0);
        step(1'b1, 1'b0, '0);
        step(1'b1, 1'b1, SYNC_WORD);
        step(1'b1, 1'b1, 32'h0000_0043);
        for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 32'h200 + W'(k));
        for (int k = 0; k < NW; k++) begin
            if (k < 3) chk("t5_new_slice", FrameData[k*W +: W], 32'h200 + W'(k));
            else       chk("t5_clear_slice", FrameData[k*W +: W], 32'h0);
        end
        for (int k = 3; k < NW; k++) step(1'b1, 1'b1, 32'h200 + W'(k));
        send_trailer(32'h0000_0043, 32'h200, 1'b0);
        chk("t5_strobe", LongFrameStrobe, 1'b1);
        step(1'b1, 1'b0, '0);
        chk("t5_frames", FramesWritten, 16'd1);

`ifdef FRAME_CHECKSUM_EN
        // Test 6: good trailer, bad trailer, then a good frame with the error still latched.
        step(1'b1, 1'b1, 32'h0000_0044);
        for (int k = 0; k < NW; k++) step(1'b1, 1'b1, 32'h300 + W'(k));
        send_trailer(32'h0000_0044, 32'h300, 1'b0);
        chk("t6_good_strobe", LongFrameStrobe, 1'b1);
        chk("t6_good_chkerr", ChkErr, 1'b0);
        step(1'b1, 1'b0, '0);
        step(1'b1, 1'b1, 32'h0000_0045);
        for (int k = 0; k < NW; k++) step(1'b1, 1'b1, 32'h400 + W'(k));
        send_trailer(32'h0000_0045, 32'h400, 1'b1);
        chk("t6_bad_strobe", LongFrameStrobe, 1'b0);
        chk("t6_bad_chkerr", ChkErr, 1'b1);
        chk("t6_bad_idle", ComActive, 1'b0);
        step(1'b1, 1'b1, SYNC_WORD);
        step(1'b1, 1'b1, 32'h0000_0046);
        for (int k = 0; k < NW; k++) step(1'b1, 1'b1, 32'h500 + W'(k));
        send_trailer(32'h0000_0046, 32'h500, 1'b0);
        chk("t6_resync_strobe", LongFrameStrobe, 1'b1);
        chk("t6_sticky_chkerr", ChkErr, 1'b1);
`endif

        // Randomized stream against the model.
        for (int i = 0; i < 4000; i++) begin
            sel = $urandom_range(0, 15);
            rd  = $urandom;
            if (sel < 2)      rd = SYNC_WORD;
            else if (sel < 3) rd = rd | 32'h0010_0000;
            else              rd = rd & 32'hFFEF_FFFF;
`ifdef FRAME_CHECKSUM_EN
            if ((m_phase == 3) && (sel < 10)) rd = m_xor();
`endif
            step(($urandom_range(0, 599) != 0), ($urandom_range(0, 3) != 0), rd);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
